// File: rtl/ysyx_22041071_ifu.sv
// ---------------------------------------------------------------------------
// ysyx_22041071_ifu
//
// Instruction-fetch stage. It holds the PC, fetches 32-bit instructions from
// instruction memory over a req/rsp handshake, and drives the IF->ID
// valid/ready link. Decode (jal) and execute (branch/jalr) can redirect the
// PC. A redirect flushes every younger instruction this stage holds or still
// has in flight.
//
// Optional feature macro: YSYX_22041071_IFU_PERF_EN
//   When defined, this module adds two free-running performance counters and
//   their output ports. When undefined, those ports and counters are absent.
//
// Ports
//   clk             in   1       single clock, all state on posedge
//   reset           in   1       synchronous, active-high
//   imem_req_valid  out  1       fetch request valid
//   imem_req_ready  in   1       memory accepts the request this cycle
//   imem_addr       out  ADDR_W  fetch address, bits[1:0] always 0
//   imem_rsp_valid  in   1       response valid, one per accepted request, in order
//   imem_rsp_data   in   INS_W   fetched instruction
//   valid2          out  1       instruction to ID is valid
//   ready2          in   1       ID can accept
//   PC2             out  ADDR_W  PC of Ins1
//   Ins1            out  INS_W   instruction to ID
//   jump_en         in   1       ID jal redirect, honoured only when valid2&ready2
//   jump_pc         in   ADDR_W  ID jal target
//   redirect_en     in   1       EX redirect, honoured in every cycle
//   redirect_pc     in   ADDR_W  EX target
//   perf_fetch_cnt  out  64      (PERF_EN only) instructions handed to ID
//   perf_flush_cnt  out  32      (PERF_EN only) cycles with a redirect
// ---------------------------------------------------------------------------
module ysyx_22041071_ifu #(
    parameter int                ADDR_W   = 64,
    parameter int                INS_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 64'h8000_0000
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rsp_valid,
    input  logic [INS_W-1:0]  imem_rsp_data,
    output logic              valid2,
    input  logic              ready2,
    output logic [ADDR_W-1:0] PC2,
    output logic [INS_W-1:0]  Ins1,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_pc,
    input  logic              redirect_en,
    input  logic [ADDR_W-1:0] redirect_pc
`ifdef YSYX_22041071_IFU_PERF_EN
    ,
    output logic [63:0]       perf_fetch_cnt,
    output logic [31:0]       perf_flush_cnt
`endif
);

    // S_REQ : ready to issue the next fetch
    // S_WAIT: one request outstanding, waiting for its response
    // S_FULL: the output register is stalled and the skid buffer is occupied
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_FULL = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] inflightPc_q, inflightPc_d;
    logic [ADDR_W-1:0] skidPc_q, skidPc_d;
    logic [INS_W-1:0]  skidIns_q, skidIns_d;
    logic              drop_q, drop_d;
    logic              valid2_q, valid2_d;
    logic [ADDR_W-1:0] pc2_q, pc2_d;
    logic [INS_W-1:0]  ins1_q, ins1_d;

    logic              fire;
    logic              redirAny;
    logic [ADDR_W-1:0] redirRaw;
    logic [ADDR_W-1:0] redirTarget;

    // Redirect decode. The jal from decode only counts on the cycle it is
    // actually handed over. The EX redirect belongs to an older instruction,
    // so it takes priority when both arrive in the same cycle. Targets are
    // forced word-aligned.
    always_comb begin
        fire        = valid2_q & ready2;
        redirAny    = redirect_en | (jump_en & fire);
        redirRaw    = redirect_en ? redirect_pc : jump_pc;
        redirTarget = {redirRaw[ADDR_W-1:2], 2'b00};
    end

    // Next-state logic for the fetch FSM and the output/skid registers.
    // A redirect overrides everything else. It loads the new PC, empties the
    // output and skid registers, and handles the in-flight request. If that
    // request's response has not arrived yet, drop_d is set so that the
    // response is thrown away when it does arrive.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        inflightPc_d   = inflightPc_q;
        skidPc_d       = skidPc_q;
        skidIns_d      = skidIns_q;
        drop_d         = drop_q;
        valid2_d       = valid2_q & ~fire;
        pc2_d          = pc2_q;
        ins1_d         = ins1_q;
        imem_req_valid = (state_q == S_REQ) & ~redirAny & ~reset;

        if (redirAny) begin
            pc_d      = redirTarget;
            valid2_d  = 1'b0;
            skidPc_d  = '0;
            skidIns_d = '0;
            case (state_q)
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        drop_d  = 1'b1;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end else begin
            case (state_q)
                S_REQ: begin
                    if (imem_req_valid & imem_req_ready) begin
                        inflightPc_d = pc_q;
                        state_d      = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        if (drop_q) begin
                            drop_d  = 1'b0;
                            state_d = S_REQ;
                        end else begin
                            pc_d = inflightPc_q + ADDR_W'(4);
                            if (!valid2_q || ready2) begin
                                valid2_d = 1'b1;
                                pc2_d    = inflightPc_q;
                                ins1_d   = imem_rsp_data;
                                state_d  = S_REQ;
                            end else begin
                                skidPc_d  = inflightPc_q;
                                skidIns_d = imem_rsp_data;
                                state_d   = S_FULL;
                            end
                        end
                    end
                end
                S_FULL: begin
                    if (fire) begin
                        valid2_d = 1'b1;
                        pc2_d    = skidPc_q;
                        ins1_d   = skidIns_q;
                        state_d  = S_REQ;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            inflightPc_q <= '0;
            skidPc_q     <= '0;
            skidIns_q    <= '0;
            drop_q       <= 1'b0;
            valid2_q     <= 1'b0;
            pc2_q        <= '0;
            ins1_q       <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inflightPc_q <= inflightPc_d;
            skidPc_q     <= skidPc_d;
            skidIns_q    <= skidIns_d;
            drop_q       <= drop_d;
            valid2_q     <= valid2_d;
            pc2_q        <= pc2_d;
            ins1_q       <= ins1_d;
        end
    end

    assign imem_addr = pc_q;
    assign valid2    = valid2_q;
    assign PC2       = pc2_q;
    assign Ins1      = ins1_q;

`ifdef YSYX_22041071_IFU_PERF_EN
    logic [63:0] perfFetch_q;
    logic [31:0] perfFlush_q;

    // Performance counters: one counts instructions accepted by decode, the
    // other counts redirect cycles. Both wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            perfFetch_q <= '0;
            perfFlush_q <= '0;
        end else begin
            if (fire) begin
                perfFetch_q <= perfFetch_q + 64'd1;
            end
            if (redirAny) begin
                perfFlush_q <= perfFlush_q + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = perfFetch_q;
    assign perf_flush_cnt = perfFlush_q;
`endif

endmodule

// File: tb/tb_ysyx_22041071_ifu.sv
// ---------------------------------------------------------------------------
// tb_ysyx_22041071_ifu
//
// Bench for the instruction-fetch stage. A memory model answers fetch
// requests with a word derived from the address, after a random latency.
// A program-order model tracks the PC that decode should see next. It is
// checked on every cycle against what the DUT hands to decode.
// ---------------------------------------------------------------------------
module tb_ysyx_22041071_ifu;

    localparam logic [63:0] RESET_PC = 64'h8000_0000;

    logic        clk;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        valid2;
    logic        ready2;
    logic [63:0] PC2;
    logic [31:0] Ins1;
    logic        jump_en;
    logic [63:0] jump_pc;
    logic        redirect_en;
    logic [63:0] redirect_pc;
`ifdef YSYX_22041071_IFU_PERF_EN
    logic [63:0] perf_fetch_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    int checks;
    int errors;

    // Memory model state.
    bit          memPend;
    int          memDelay;
    logic [63:0] memAddr;
    bit          mAcc;
    bit          mRst;
    bit          mRspNow;
    logic [63:0] mAccAddr;
    int          memMinLat;
    int          memMaxLat;
    int unsigned readyPct;

    // Program-order model state.
    logic [63:0] expPc;
    bit          prevHold;
    logic [63:0] holdPc;
    logic [31:0] holdIns;
    int          stallCnt;

    ysyx_22041071_ifu dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .valid2         (valid2),
        .ready2         (ready2),
        .PC2            (PC2),
        .Ins1           (Ins1),
        .jump_en        (jump_en),
        .jump_pc        (jump_pc),
        .redirect_en    (redirect_en),
        .redirect_pc    (redirect_pc)
`ifdef YSYX_22041071_IFU_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents: a fixed scramble of the address, so that
    // an instruction paired with the wrong PC is detected.
    function automatic logic [31:0] memWord(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0013_0513;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Program-order model, evaluated once per cycle on the falling edge.
    task automatic modelCompare();
        if (reset) begin
            expPc    = RESET_PC;
            prevHold = 0;
            stallCnt = 0;
            return;
        end
        if (imem_req_valid) begin
            checkOutput("reqAlign", 64'(imem_addr[1:0]), 64'h0);
            checkOutput("oneOutstanding", 64'(memPend), 64'h0);
        end
        if (redirect_en || (jump_en && valid2 && ready2))
            checkOutput("noReqOnRedirect", 64'(imem_req_valid), 64'h0);
        if (prevHold) begin
            checkOutput("holdValid", 64'(valid2), 64'h1);
            checkOutput("holdPc", PC2, holdPc);
            checkOutput("holdIns", 64'(Ins1), 64'(holdIns));
        end
        stallCnt++;
        if (redirect_en) begin
            expPc    = {redirect_pc[63:2], 2'b00};
            stallCnt = 0;
        end else if (valid2 && ready2) begin
            checkOutput("streamPc", PC2, expPc);
            checkOutput("streamIns", 64'(Ins1), 64'(memWord(expPc)));
            expPc    = jump_en ? {jump_pc[63:2], 2'b00} : expPc + 64'd4;
            stallCnt = 0;
        end
        if (stallCnt >= 200) begin
            checks++;
            errors++;
            $display("[TB] FAIL progress no handover for %0d cycles", stallCnt);
            stallCnt = 0;
        end
        prevHold = valid2 && !ready2 && !redirect_en;
        holdPc   = PC2;
        holdIns  = Ins1;
    endtask

    // Drives one cycle: inputs and the memory response just after the
    // rising edge, then checks and samples the memory handshake on the
    // falling edge.
    task automatic applyStimulus(input bit rst, input bit r2, input bit rEn,
                                 input logic [63:0] rPc, input bit jEn, input logic [63:0] jPc);
        @(posedge clk);
        #1;
        reset       = rst;
        ready2      = r2;
        redirect_en = rEn;
        redirect_pc = rPc;
        jump_en     = jEn;
        jump_pc     = jPc;
        if (mRst) begin
            memPend = 0;
        end else begin
            if (mRspNow) memPend = 0;
            if (mAcc) begin
                memPend  = 1;
                memAddr  = mAccAddr;
                memDelay = $urandom_range(memMaxLat, memMinLat);
            end
        end
        if (memPend && memDelay == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memWord(memAddr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
            if (memPend) memDelay--;
        end
        imem_req_ready = ($urandom_range(99, 0) < readyPct);
        @(negedge clk);
        modelCompare();
        mAcc     = imem_req_valid && imem_req_ready;
        mAccAddr = imem_addr;
        mRst     = reset;
        mRspNow  = imem_rsp_valid;
    endtask

    task automatic idle(input bit r2);
        applyStimulus(1'b0, r2, 1'b0, 64'h0, 1'b0, 64'h0);
    endtask

    task automatic resetDut();
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0);
    endtask

    task automatic waitValid(input string name);
        int n;
        n = 0;
        do begin
            idle(1'b0);
            n++;
        end while (!valid2 && n < 40);
        if (!valid2) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s timeout valid2=0 expected 1", name);
        end
    endtask

    initial begin
        bit          rst, r2, rEn, jEn;
        logic [63:0] rPc, jPc;
        checks = 0; errors = 0;
        reset = 1'b1; ready2 = 1'b0; jump_en = 1'b0; jump_pc = '0;
        redirect_en = 1'b0; redirect_pc = '0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        memPend = 0; memDelay = 0; memAddr = '0; mAcc = 0; mRst = 1; mRspNow = 0; mAccAddr = '0;
        memMinLat = 0; memMaxLat = 0; readyPct = 100;
        expPc = RESET_PC; prevHold = 0; holdPc = '0; holdIns = '0; stallCnt = 0;

        // Reset values, then the basic fetch cadence with a 1-cycle memory.
        resetDut();
        checkOutput("rstValid2", 64'(valid2), 64'h0);
        checkOutput("rstPC2", PC2, 64'h0);
        checkOutput("rstIns1", 64'(Ins1), 64'h0);
        checkOutput("rstReqValid", 64'(imem_req_valid), 64'h0);
        for (int i = 0; i < 7; i++) begin
            idle(1'b1);
            checkOutput("cadReqValid", 64'(imem_req_valid), 64'((i % 2) == 0));
            checkOutput("cadValid2", 64'(valid2), 64'((i >= 2) && (i % 2) == 0));
            if ((i % 2) == 0) checkOutput("cadAddr", imem_addr, 64'h8000_0000 + 64'(2 * i));
            if (i >= 2 && (i % 2) == 0) checkOutput("cadPC2", PC2, 64'h8000_0000 + 64'(2 * (i - 2)));
            if (i == 2) checkOutput("cadIns0", 64'(Ins1), 64'h8013_0513);
            if (i == 4) checkOutput("cadIns1", 64'(Ins1), 64'hF8CE_E3D7);
        end

        // Back-pressure: the output holds, the skid buffer fills, and no
        // request is issued until decode drains both.
        resetDut();
        idle(1'b1);
        idle(1'b1);
        for (int k = 0; k < 5; k++) begin
            idle(1'b0);
            checkOutput("bpValid2", 64'(valid2), 64'h1);
            checkOutput("bpPC2", PC2, 64'h8000_0000);
            if (k >= 1) checkOutput("bpNoReq", 64'(imem_req_valid), 64'h0);
        end
        idle(1'b1);
        checkOutput("bpDrain0", PC2, 64'h8000_0000);
        idle(1'b1);
        checkOutput("bpDrain1Valid", 64'(valid2), 64'h1);
        checkOutput("bpDrain1", PC2, 64'h8000_0004);
        checkOutput("bpNextReqValid", 64'(imem_req_valid), 64'h1);
        checkOutput("bpNextReq", imem_addr, 64'h8000_0008);

        // EX redirect while a response is outstanding: it is dropped.
        memMinLat = 2; memMaxLat = 2;
        resetDut();
        idle(1'b1);
        checkOutput("exReq0", imem_addr, 64'h8000_0000);
        applyStimulus(1'b0, 1'b1, 1'b1, 64'h8000_0103, 1'b0, 64'h0);
        checkOutput("exReqBlocked", 64'(imem_req_valid), 64'h0);
        idle(1'b1);
        checkOutput("exDropV2a", 64'(valid2), 64'h0);
        idle(1'b1);
        checkOutput("exDropV2b", 64'(valid2), 64'h0);
        idle(1'b1);
        checkOutput("exNewReqValid", 64'(imem_req_valid), 64'h1);
        checkOutput("exNewReq", imem_addr, 64'h8000_0100);
        checkOutput("exDropV2c", 64'(valid2), 64'h0);
        waitValid("exWait");
        checkOutput("exPC2", PC2, 64'h8000_0100);
        memMinLat = 0; memMaxLat = 0;

        // Decode jal: taken on handover, ignored while decode stalls.
        resetDut();
        waitValid("jalWait0");
        checkOutput("jalPC0", PC2, 64'h8000_0000);
        applyStimulus(1'b0, 1'b1, 1'b0, 64'h0, 1'b1, 64'h8000_0200);
        waitValid("jalWait1");
        checkOutput("jalTarget", PC2, 64'h8000_0200);
        applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 64'h8000_0400);
        checkOutput("jalStallHold", PC2, 64'h8000_0200);
        idle(1'b1);
        waitValid("jalWait2");
        checkOutput("jalIgnored", PC2, 64'h8000_0204);
`ifdef YSYX_22041071_IFU_PERF_EN
        checkOutput("perfFetch", perf_fetch_cnt, 64'd2);
        checkOutput("perfFlush", 64'(perf_flush_cnt), 64'd1);
`endif

        // EX redirect and decode jal in the same cycle: EX wins.
        resetDut();
        waitValid("bothWait0");
        applyStimulus(1'b0, 1'b1, 1'b1, 64'h8000_0300, 1'b1, 64'h8000_0200);
        waitValid("bothWait1");
        checkOutput("bothPC2", PC2, 64'h8000_0300);

        // Reset while the skid buffer is full.
        resetDut();
        waitValid("fullWait");
        idle(1'b0);
        idle(1'b0);
        checkOutput("fullNoReq", 64'(imem_req_valid), 64'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0);
        idle(1'b0);
        checkOutput("rstFullValid2", 64'(valid2), 64'h0);
        checkOutput("rstFullReqValid", 64'(imem_req_valid), 64'h1);
        checkOutput("rstFullAddr", imem_addr, 64'h8000_0000);
`ifdef YSYX_22041071_IFU_PERF_EN
        checkOutput("rstPerfFetch", perf_fetch_cnt, 64'd0);
        checkOutput("rstPerfFlush", 64'(perf_flush_cnt), 64'd0);
`endif

        // PC wrap at the top of the address space.
        applyStimulus(1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 64'h0);
        waitValid("wrapWait0");
        checkOutput("wrapTop", PC2, 64'hFFFF_FFFF_FFFF_FFFC);
        idle(1'b1);
        waitValid("wrapWait1");
        checkOutput("wrapZero", PC2, 64'h0);

        // Random traffic against the program-order model.
        memMinLat = 0; memMaxLat = 3; readyPct = 70;
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(499, 0) == 0);
            r2  = ($urandom_range(99, 0) < 70);
            rEn = ($urandom_range(99, 0) < 4);
            jEn = ($urandom_range(99, 0) < 8);
            rPc = {32'h0, 32'h8000_0000 | 32'($urandom_range(65535, 0))};
            jPc = {32'h0, 32'h8000_0000 | 32'($urandom_range(65535, 0))};
            applyStimulus(rst, r2, rEn, rPc, jEn, jPc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
